uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//  - UART receive front end; feeds the command/length frame parser (rok/mosi byte stream).
//  - Samples async serial line rxd, 8N1, LSB first; one-cycle rok strobe per good byte.
//  - Flags framing (and optional parity) errors; no byte delivered on error.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); legal range 8..65535
//  SYNC_STAGES   2    rxd synchroniser depth; legal range 2..4
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous reset, active high
//  rxd        in   1   async serial input, idle high
//  mosi       out  8   last good received byte; held until next good byte
//  rok        out  1   one-cycle strobe: mosi valid and new
//  frame_err  out  1   one-cycle strobe: stop bit sampled low
//  parity_err out  1   one-cycle strobe: parity mismatch (0 when UART_PARITY_EN undefined)
//  rx_busy    out  1   high from start-bit detect until return to IDLE
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): all synchroniser flops 1, state IDLE, bit/baud counters 0,
//    mosi=8'h00, rok=0, frame_err=0, parity_err=0, rx_busy=0. Reset overrides any frame in flight.
//  - rxd passes SYNC_STAGES flops -> rxs; all decisions use rxs only.
//  - Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1, wraps to 0; cleared on every state change.
//  - States:
//    IDLE : rxs==0 -> START, clear counter, rx_busy=1.
//    START: at count==CLKS_PER_BIT/2-1 (integer div): rxs==1 -> IDLE (glitch, no strobe);
//           rxs==0 -> DATA, bit index 0, counter cleared (mid-bit alignment).
//    DATA : at count==CLKS_PER_BIT-1 sample rxs into shift reg bit[idx]; idx 7 sampled -> PARITY
//           (if enabled) else STOP; else idx+1.
//    PARITY: at count==CLKS_PER_BIT-1 sample; mismatch recorded, checked at STOP.
//    STOP : at count==CLKS_PER_BIT-1 sample rxs:
//           1 and no parity error -> mosi<=shift, rok=1 next cycle, -> IDLE;
//           1 with parity error -> parity_err=1, mosi unchanged, -> IDLE;
//           0 -> frame_err=1 (takes priority over parity_err, which stays 0), mosi unchanged, -> BRK.
//    BRK  : wait until rxs==1, then -> IDLE (no new start detect during break).
//  - rx_busy=0 only in IDLE. Strobes never overlap; each is exactly one cycle.
//  - Latency: rok asserts SYNC_STAGES+1 cycles after mid-stop-bit on rxd, nominal.
//  - Back-to-back frames: start edge accepted the first cycle IDLE sees rxs==0; no idle gap required.
//  - rok is not backpressured; consumer must accept every strobe.
// CONFIGURATION
//  - UART_PARITY_EN defined: frame 8E1; PARITY state inserted; even parity
//    (XOR of 8 data bits and parity bit must be 0); parity_err driven as above.
//  - UART_PARITY_EN undefined: frame 8N1; no PARITY state; parity_err tied 0.
// TESTING  (CLKS_PER_BIT=16, SYNC_STAGES=2)
//  - Reset: rst=1 for 3 cycles with rxd toggling -> mosi=00, all strobes 0, rx_busy=0.
//  - Send 8'hA5 8N1 -> one rok pulse, mosi=A5, frame_err=0; rx_busy drops after rok.
//  - Send 03,00,5A back-to-back, no idle gap -> three rok pulses; mosi 03, 00, 5A in order.
//  - rxd low 4 cycles then high (glitch) -> no strobe, rx_busy returns 0 by cycle 12.
//  - Send 8'h3C with stop bit low, hold rxd low 40 cycles, release -> frame_err pulse,
//    mosi unchanged, no rok; next frame 8'h11 -> rok, mosi=11.
//  - UART_PARITY_EN: 8'h07 with parity 1 -> rok, mosi=07; with parity 0 -> parity_err, no rok.

Source files
------------

// File: rtl/uart_byte_rx.sv
// +-----------------------------------------------------------------------------+
// | Module      : uart_byte_rx                                                  |
// | Description : UART byte receiver, 8N1 (8E1 when UART_PARITY_EN is defined), |
// |               one-cycle rok / frame_err / parity_err strobes.               |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] mosi,
  output logic       rok,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

`ifdef UART_PARITY_EN
  localparam bit c_parity_en = 1'b1;
`else
  localparam bit c_parity_en = 1'b0;
`endif

  localparam logic [15:0] c_full = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] c_half = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } state_t;

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [15:0]            r_cnt, w_cnt_next;
  logic [2:0]             r_idx, w_idx_next;
  logic [7:0]             r_shift, w_shift_next;
  logic                   r_par_bad, w_par_bad_next;
  logic [7:0]             r_mosi, w_mosi_next;
  logic                   r_rok, w_rok_next;
  logic                   r_ferr, w_ferr_next;
  logic                   r_perr, w_perr_next;
  logic                   w_rxs;

  assign w_rxs = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_mosi    <= 8'h00;
      r_rok     <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rxd};
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_shift   <= w_shift_next;
      r_par_bad <= w_par_bad_next;
      r_mosi    <= w_mosi_next;
      r_rok     <= w_rok_next;
      r_ferr    <= w_ferr_next;
      r_perr    <= w_perr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = (r_cnt == c_full) ? 16'd0 : r_cnt + 16'd1;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_par_bad_next = r_par_bad;
    w_mosi_next    = r_mosi;
    w_rok_next     = 1'b0;
    w_ferr_next    = 1'b0;
    w_perr_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_par_bad_next = 1'b0;
        if (!w_rxs) w_state_next = S_START;
      end
      S_START: begin
        // Re-check at mid start bit so the data samples land mid-bit too.
        if (r_cnt == c_half) begin
          if (w_rxs) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DATA;
            w_idx_next   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == c_full) begin
          w_shift_next[r_idx] = w_rxs;
          if (r_idx == 3'd7) w_state_next = c_parity_en ? S_PARITY : S_STOP;
          else               w_idx_next   = r_idx + 3'd1;
        end
      end
      S_PARITY: begin
        if (r_cnt == c_full) begin
          w_par_bad_next = (^r_shift) ^ w_rxs;
          w_state_next   = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == c_full) begin
          if (w_rxs) begin
            w_state_next = S_IDLE;
            if (r_par_bad) begin
              w_perr_next = 1'b1;
            end else begin
              w_mosi_next = r_shift;
              w_rok_next  = 1'b1;
            end
          end else begin
            // Framing error wins over parity; wait out the break before rearming.
            w_ferr_next  = 1'b1;
            w_state_next = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (w_rxs) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_state_next != r_state) w_cnt_next = 16'd0;
  end

  assign mosi       = r_mosi;
  assign rok        = r_rok;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr & c_parity_en;
  assign rx_busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_uart_byte_rx                                               |
// | Description : Scoreboard bench for uart_byte_rx at 16 clocks per bit.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_byte_rx;

  localparam int c_cpb = 16;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] mosi;
  logic       rok;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;
  int n_rok = 0;
  int n_ferr = 0;
  int n_perr = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [2:0] kind;   // {rok, frame_err, parity_err}
    logic [7:0] data;
  } ev_t;
  ev_t q[$];

  uart_byte_rx #(.CLKS_PER_BIT(c_cpb), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .mosi      (mosi),
    .rok       (rok),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (rst === 1'b0 && (rok === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1)) begin
      if (rok === 1'b1)        n_rok++;
      if (frame_err === 1'b1)  n_ferr++;
      if (parity_err === 1'b1) n_perr++;
      if (q.size() == 0) begin
        chk("unexpected_strobe", {29'd0, rok, frame_err, parity_err}, 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("strobe_kind", {29'd0, rok, frame_err, parity_err}, {29'd0, e.kind});
        chk("mosi", {24'd0, mosi}, {24'd0, e.data});
      end
    end
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (c_cpb) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] d, input logic pbit, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
    drive_bit(pbit);
`else
    if (pbit !== ^d) $display("note: parity bit ignored in 8N1 build");
`endif
    drive_bit(stop);
  endtask

  task automatic send_good(input logic [7:0] d);
    q.push_back('{kind: 3'b100, data: d});
    last_good = d;
    send_raw(d, ^d, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      @(negedge clk);
    end
    rxd = 1'b1;
    chk("rst_mosi", {24'd0, mosi}, 32'h00);
    chk("rst_rok", {31'd0, rok}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy", {31'd0, rx_busy}, 32'd0);

    // Single byte, with a busy check during the first data bit.
    fork
      send_good(8'hA5);
      begin
        repeat (c_cpb + 8) @(negedge clk);
        chk("busy_mid", {31'd0, rx_busy}, 32'd1);
      end
    join
    wait_drain();
    chk("a5_rok_cnt", n_rok, 1);
    chk("a5_mosi", {24'd0, mosi}, 32'hA5);
    chk("a5_busy_after", {31'd0, rx_busy}, 32'd0);

    // Back-to-back frames with no idle gap.
    send_good(8'h03);
    send_good(8'h00);
    send_good(8'h5A);
    wait_drain();
    chk("b2b_rok_cnt", n_rok, 4);
    chk("b2b_mosi", {24'd0, mosi}, 32'h5A);

    // Start-bit glitch.
    repeat (10) @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("glitch_rok_cnt", n_rok, 4);
    chk("glitch_ferr_cnt", n_ferr, 0);

    // Framing error followed by a line break, then recovery.
    q.push_back('{kind: 3'b010, data: last_good});
    send_raw(8'h3C, ^8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (40 - c_cpb) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    wait_drain();
    chk("ferr_cnt", n_ferr, 1);
    chk("ferr_rok_cnt", n_rok, 4);
    chk("ferr_mosi", {24'd0, mosi}, 32'h5A);
    chk("ferr_busy", {31'd0, rx_busy}, 32'd0);
    send_good(8'h11);
    wait_drain();
    chk("rec_rok_cnt", n_rok, 5);
    chk("rec_mosi", {24'd0, mosi}, 32'h11);

`ifdef UART_PARITY_EN
    // 8'h07 has three ones, so even parity needs parity bit 1.
    q.push_back('{kind: 3'b100, data: 8'h07});
    send_raw(8'h07, 1'b1, 1'b1);
    wait_drain();
    chk("par_ok_mosi", {24'd0, mosi}, 32'h07);
    q.push_back('{kind: 3'b001, data: 8'h07});
    send_raw(8'h07, 1'b0, 1'b1);
    wait_drain();
    chk("par_bad_cnt", n_perr, 1);
    chk("par_bad_rok_cnt", n_rok, 6);
`else
    chk("perr_cnt", n_perr, 0);
`endif

    repeat (20) @(negedge clk);
    chk("end_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
